// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage state encoding, payload field widths and default bubble.
package pipe_stage_reg_pkg;

    localparam int unsigned FwdW     = 1;
    localparam int unsigned RdAddrW  = 5;
    localparam int unsigned RdValW   = 32;
    localparam int unsigned InsTypeW = 7;
    localparam int unsigned InsDetW  = 3;
    localparam int unsigned MemAddrW = 32;
    localparam int unsigned MemValW  = 32;

    localparam int unsigned PayloadW =
        FwdW + RdAddrW + RdValW + InsTypeW + InsDetW + MemAddrW + MemValW;

    localparam logic [PayloadW-1:0] BubbleVal = '0;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } stage_state_e;

    // Held-entry count for a state; the encoding is chosen so this is the identity.
    function automatic logic [1:0] occ_of(stage_state_e s);
        return logic'(s == StFull) ? 2'd1 : (s == StSkid) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// global enable (rdy_in) and synchronous flush.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned          PAYLOAD_W  = PayloadW,
    parameter bit                   SKID_EN    = 1'b1,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = PAYLOAD_W'(BubbleVal)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 up_valid_in,
    output logic                 up_ready_out,
    input  logic [PAYLOAD_W-1:0] up_payload_in,
    output logic                 dn_valid_out,
    input  logic                 dn_ready_in,
    output logic [PAYLOAD_W-1:0] dn_payload_out,
    output logic [1:0]           occupancy_out
);

    stage_state_e         r_state, w_state_nxt;
    logic [PAYLOAD_W-1:0] r_main, w_main_nxt;
    logic [PAYLOAD_W-1:0] r_skid, w_skid_nxt;
    logic [1:0]           r_occ, w_occ_nxt;
    logic                 w_up_ready, w_dn_valid;
    logic                 w_up_fire, w_dn_fire;

    // In skid mode ready depends only on held state; single-entry mode may pass
    // downstream ready straight through while full.
    always_comb begin
        w_up_ready = 1'b0;
        w_dn_valid = rdy_in && (r_state != StEmpty);
        if (rst_n_in && rdy_in) begin
            case (r_state)
                StEmpty: w_up_ready = 1'b1;
                StFull:  w_up_ready = SKID_EN ? 1'b1 : dn_ready_in;
                default: w_up_ready = 1'b0;
            endcase
        end
        w_up_fire = up_valid_in && w_up_ready;
        w_dn_fire = w_dn_valid && dn_ready_in;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush_in) begin
            w_state_nxt = StEmpty;
            w_main_nxt  = BUBBLE_VAL;
            w_skid_nxt  = BUBBLE_VAL;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_up_fire) begin
                        w_state_nxt = StFull;
                        w_main_nxt  = up_payload_in;
                    end
                end
                StFull: begin
                    if (w_up_fire && w_dn_fire) begin
                        w_main_nxt = up_payload_in;
                    end else if (w_dn_fire) begin
                        w_state_nxt = StEmpty;
                        w_main_nxt  = BUBBLE_VAL;
                    end else if (w_up_fire && SKID_EN) begin
                        w_state_nxt = StSkid;
                        w_skid_nxt  = up_payload_in;
                    end
                end
                StSkid: begin
                    if (w_dn_fire) begin
                        w_state_nxt = StFull;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE_VAL;
                    end
                end
                default: begin
                    w_state_nxt = StEmpty;
                    w_main_nxt  = BUBBLE_VAL;
                    w_skid_nxt  = BUBBLE_VAL;
                end
            endcase
        end
        w_occ_nxt = occ_of(w_state_nxt);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= StEmpty;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
            r_occ   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    assign up_ready_out   = w_up_ready;
    assign dn_valid_out   = w_dn_valid;
    assign dn_payload_out = r_main;
    assign occupancy_out  = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid-mode and a single-entry-mode stage with shared stimulus and checks
// both against per-instance in-order queues of accepted entries.
module tb_pipe_stage_reg;

    localparam int unsigned W = 112;
    localparam logic [W-1:0] BUB = 112'hDEAD_BEEF_0000_0000_0000_0000_0001;

    logic         clk = 1'b0;
    logic         rst_n, rdy, flush, up_valid, dn_ready;
    logic [W-1:0] up_payload;

    logic         up_ready   [2];
    logic         dn_valid   [2];
    logic [W-1:0] dn_payload [2];
    logic [1:0]   occ        [2];

    logic [W-1:0] sb [2][$];
    int           pushed_now [2] = '{0, 0};
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.PAYLOAD_W(W), .SKID_EN(1'b1), .BUBBLE_VAL(BUB)) u_dut_skid (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .up_valid_in(up_valid), .up_ready_out(up_ready[0]), .up_payload_in(up_payload),
        .dn_valid_out(dn_valid[0]), .dn_ready_in(dn_ready), .dn_payload_out(dn_payload[0]),
        .occupancy_out(occ[0])
    );

    pipe_stage_reg #(.PAYLOAD_W(W), .SKID_EN(1'b0), .BUBBLE_VAL(BUB)) u_dut_single (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .up_valid_in(up_valid), .up_ready_out(up_ready[1]), .up_payload_in(up_payload),
        .dn_valid_out(dn_valid[1]), .dn_ready_in(dn_ready), .dn_payload_out(dn_payload[1]),
        .occupancy_out(occ[1])
    );

    task automatic check(input string name, input int inst, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_payload();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Stimulus: drive after the edge, then record every entry the DUT accepted.
    task automatic cyc(input logic v, input logic [W-1:0] p, input logic dr, input logic r,
                       input logic fl);
        @(posedge clk);
        #1;
        up_valid   = v;
        up_payload = p;
        dn_ready   = dr;
        rdy        = r;
        flush      = fl;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst_n && rdy && !flush && up_valid && up_ready[i]) begin
                sb[i].push_back(up_payload);
                pushed_now[i] = 1;
            end
        end
    endtask

    task automatic async_reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_rst_occ", i, W'(occ[i]), W'(0));
            check("async_rst_dn_valid", i, W'(dn_valid[i]), W'(0));
            check("async_rst_up_ready", i, W'(up_ready[i]), W'(0));
            check("async_rst_payload", i, dn_payload[i], BUB);
            sb[i].delete();
            pushed_now[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every output against the queue of held entries, popping on consume.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int           held;
            logic         exp_ur;
            logic [W-1:0] exp_p;
            if (!rst_n) begin
                check("rst_occ", i, W'(occ[i]), W'(0));
                check("rst_dn_valid", i, W'(dn_valid[i]), W'(0));
                check("rst_up_ready", i, W'(up_ready[i]), W'(0));
                check("rst_payload", i, dn_payload[i], BUB);
            end else begin
                held   = sb[i].size() - pushed_now[i];
                exp_ur = rdy && ((i == 0) ? (held < 2) : (held == 0 || dn_ready));
                check("occupancy", i, W'(occ[i]), W'(held));
                check("dn_valid", i, W'(dn_valid[i]), W'(rdy && held > 0));
                check("up_ready", i, W'(up_ready[i]), W'(exp_ur));
                if (held == 0) begin
                    check("bubble", i, dn_payload[i], BUB);
                end else if (rdy && dn_ready && !flush) begin
                    exp_p = sb[i].pop_front();
                    check("scoreboard", i, dn_payload[i], exp_p);
                end else begin
                    check("head", i, dn_payload[i], sb[i][0]);
                end
                if (flush) sb[i].delete();
            end
            pushed_now[i] = 0;
        end
    end

    initial begin
        rst_n      = 1'b0;
        rdy        = 1'b1;
        flush      = 1'b0;
        up_valid   = 1'b0;
        dn_ready   = 1'b0;
        up_payload = '0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // First accept into EMPTY, then a second offer that fills the skid entry.
        cyc(1'b1, W'(112'h0A), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, W'(112'h0B), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, W'(0), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, W'(112'h0C), 1'b1, 1'b1, 1'b0);
        cyc(1'b0, W'(0), 1'b1, 1'b1, 1'b0);
        cyc(1'b0, W'(0), 1'b1, 1'b1, 1'b0);

        // Flush while holding two entries with a new offer on the same edge.
        cyc(1'b1, W'(112'h0D), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, W'(112'h0E), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, W'(112'h0F), 1'b1, 1'b1, 1'b1);
        cyc(1'b0, W'(0), 1'b0, 1'b1, 1'b0);

        // Global enable low freezes everything despite valid/ready high.
        cyc(1'b1, W'(112'h10), 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, W'(112'h11), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, W'(112'h11), 1'b1, 1'b1, 1'b0);
        cyc(1'b0, W'(0), 1'b1, 1'b1, 1'b0);

        // Asynchronous reset while in SKID, then restart from EMPTY.
        cyc(1'b1, W'(112'h12), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, W'(112'h13), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, W'(0), 1'b0, 1'b1, 1'b0);
        async_reset_mid();
        cyc(1'b1, W'(112'h14), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, W'(0), 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            cyc(($urandom % 4) != 0, rnd_payload(), ($urandom % 3) != 0,
                ($urandom % 8) != 0, ($urandom % 32) == 0);
        end
        cyc(1'b0, W'(0), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 112, sets payload width: forward(1)+rd_addr(5)+rd_val(32)+ins_type(7)+ins_details(3)+mem_addr(32)+mem_val(32).
REQ-002 Parameter SKID_EN, default 1; 1 = two-entry skid mode, 0 = single-entry mode.
REQ-003 Parameter BUBBLE_VAL, default all-zero, PAYLOAD_W bits, is the payload presented when no valid entry is held.
REQ-004 Port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 Port rdy_in  input  1  global enable; low freezes all state.
REQ-007 Port flush_in  input  1  synchronous discard of all held entries.
REQ-008 Port up_valid_in  input  1  upstream entry offered.
REQ-009 Port up_ready_out  output  1  stage accepts an offered entry this cycle.
REQ-010 Port up_payload_in  input  PAYLOAD_W  upstream entry.
REQ-011 Port dn_valid_out  output  1  dn_payload_out holds a valid entry.
REQ-012 Port dn_ready_in  input  1  downstream consumes a valid entry this cycle.
REQ-013 Port dn_payload_out  output  PAYLOAD_W  oldest held entry, driven directly from a register.
REQ-014 Port occupancy_out  output  2  number of held entries, 0..2.

Function
REQ-015 Transfers occur only on edges where valid, ready and rdy_in are all high.
REQ-016 States: EMPTY (0 entries), FULL (1, in main register), SKID (2, main plus skid register); SKID is unreachable when SKID_EN=0.
REQ-017 EMPTY: up_ready_out=1, dn_valid_out=0; accept -> FULL with main<=up_payload_in.
REQ-018 FULL, SKID_EN=1: up_ready_out=1, dn_valid_out=1; accept+consume -> FULL, main<=input; consume only -> EMPTY; accept only -> SKID, skid<=input; neither -> hold.
REQ-019 FULL, SKID_EN=0: up_ready_out=dn_ready_in (combinational path permitted only in this mode); transitions otherwise as REQ-018 without SKID.
REQ-020 SKID: up_ready_out=0, dn_valid_out=1; consume -> FULL, main<=skid; otherwise hold.
REQ-021 With SKID_EN=1, up_ready_out is a function of registered state and rdy_in only.
REQ-022 Entries leave in arrival order; no entry is duplicated or dropped except by flush or reset.
REQ-023 rdy_in low: up_ready_out=0, dn_valid_out=0, state and registers unchanged.
REQ-024 flush_in high: next state EMPTY, main and skid <= BUBBLE_VAL; same-edge input is discarded; flush overrides rdy_in.
REQ-025 Entering EMPTY by drain loads main with BUBBLE_VAL, so dn_payload_out=BUBBLE_VAL whenever state is EMPTY.
REQ-026 Latency: an entry accepted into EMPTY appears on dn_payload_out with dn_valid_out=1 the next cycle.
REQ-027 occupancy_out is 0/1/2 for EMPTY/FULL/SKID, registered.

Reset
REQ-028 rst_n_in low asynchronously forces EMPTY, main=skid=BUBBLE_VAL, occupancy_out=0, dn_valid_out=0.
REQ-029 Reset mid-transfer discards all entries; the first accept after deassertion behaves as from EMPTY.
REQ-030 up_ready_out is 0 while rst_n_in is low.

Structure
REQ-031 State encoding, the payload field widths, and the default BUBBLE_VAL constant reside in the shared pipeline package.
REQ-032 Single module, no sub-modules; stage instances (EX/MEM and others) pack and unpack fields at the instantiation site.

Verification
REQ-033 Reset then up_valid_in=1, payload 0x...0A -> next cycle dn_valid_out=1, dn_payload_out=0x...0A, occupancy_out=1.
REQ-034 SKID_EN=1, dn_ready_in=0, offer A then B -> occupancy_out=2, up_ready_out=0; raise dn_ready_in -> A then B on consecutive cycles.
REQ-035 SKID_EN=0, FULL, dn_ready_in=0, up_valid_in=1 -> up_ready_out=0, no state change; dn_ready_in=1 -> accept and consume on the same edge.
REQ-036 SKID state, flush_in=1 with up_valid_in=1 -> next cycle occupancy_out=0, dn_valid_out=0, dn_payload_out=BUBBLE_VAL.
REQ-037 rdy_in=0 for 3 cycles with valid/ready high -> no transfers, occupancy_out unchanged; rdy_in=1 -> transfers resume.
REQ-038 Assert rst_n_in low between clock edges while in SKID -> outputs immediately at reset values; 1000 random valid/ready cycles match an in-order scoreboard.
